// File: rtl/soqpsk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soqpsk_pkg
// Description : Shared types, alpha codes, address layout and the SOQPSK
//               ternary precoder function for the waveform LUT reader.
// Revision    : 1.0  initial release
// ============================================================================
package soqpsk_pkg;

  // Ternary symbol code: 00 = 0, 01 = +1, 11 = -1 (10 never produced)
  typedef logic [1:0] alpha_t;

  localparam alpha_t ALPHA_ZERO = 2'b00;
  localparam alpha_t ALPHA_POS  = 2'b01;
  localparam alpha_t ALPHA_NEG  = 2'b11;

  // ROM address layout {alpha_cur, alpha_prev, idx} for the default 32 sps
  localparam int SPS_LOG2_DEF  = 5;
  localparam int ADDR_IDX_LSB  = 0;
  localparam int ADDR_PREV_LSB = SPS_LOG2_DEF;
  localparam int ADDR_CUR_LSB  = SPS_LOG2_DEF + 2;

  // Bits map 1 -> +1, 0 -> -1. alpha is 0 when a_k equals a_{k-2};
  // otherwise its sign is (-1)^(k+1)*a_{k-1}*a_k, which in bit form is
  // positive exactly when a_k ^ a_{k-1} ^ parity(k) is 1.
  function automatic alpha_t soqpsk_precode(input logic a_k,
                                            input logic a_km1,
                                            input logic a_km2,
                                            input logic parity);
    alpha_t res;
    res = ALPHA_ZERO;
    if (a_k != a_km2) begin
      res = (a_k ^ a_km1 ^ parity) ? ALPHA_POS : ALPHA_NEG;
    end
    return res;
  endfunction

endpackage : soqpsk_pkg
`default_nettype wire

// File: rtl/soqpsk_precoder.sv
`default_nettype none
// ============================================================================
// Module      : soqpsk_precoder
// Description : Holds the two-bit data history and symbol parity; presents
//               the alpha for the offered bit and advances on load.
// Revision    : 1.0  initial release
// ============================================================================
module soqpsk_precoder
  import soqpsk_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   clear,
  input  logic   load,
  input  logic   bit_in,
  output alpha_t alpha
);

  logic a_km1_q, a_km1_d;
  logic a_km2_q, a_km2_d;
  logic parity_q, parity_d;

  // Alpha for the candidate bit against the current history
  assign alpha = soqpsk_precode(bit_in, a_km1_q, a_km2_q, parity_q);

  // History shift on load; clear returns to the post-reset history of +1,+1
  always_comb begin
    a_km1_d  = a_km1_q;
    a_km2_d  = a_km2_q;
    parity_d = parity_q;
    if (clear) begin
      a_km1_d  = 1'b1;
      a_km2_d  = 1'b1;
      parity_d = 1'b0;
    end else if (load) begin
      a_km1_d  = bit_in;
      a_km2_d  = a_km1_q;
      parity_d = ~parity_q;
    end
  end

  // History and parity registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_km1_q  <= 1'b1;
      a_km2_q  <= 1'b1;
      parity_q <= 1'b0;
    end else begin
      a_km1_q  <= a_km1_d;
      a_km2_q  <= a_km2_d;
      parity_q <= parity_d;
    end
  end

endmodule : soqpsk_precoder
`default_nettype wire

// File: rtl/soqpsk_lut_reader.sv
`default_nettype none
// ============================================================================
// Module      : soqpsk_lut_reader
// Description : SOQPSK modulator front end. Precodes the serial bit stream
//               into ternary symbols and drives the 512x14 waveform ROM
//               address, returning samples with an aligned valid strobe.
// Revision    : 1.0  initial release
// ============================================================================
module soqpsk_lut_reader
  import soqpsk_pkg::*;
#(
  parameter int SPS_LOG2 = 5,
  parameter int ADDR_W   = 9,   // must equal 4 + SPS_LOG2
  parameter int DATA_W   = 14,
  parameter int ROM_LAT  = 2    // must be at least 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tx_en,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              underrun
);

  localparam logic [SPS_LOG2-1:0] IDX_LAST = '1;

  logic [SPS_LOG2-1:0] idx_q, idx_d;
  alpha_t              alpha_cur_q, alpha_cur_d;
  alpha_t              alpha_prev_q, alpha_prev_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic [ROM_LAT:0]    vpipe_q, vpipe_d;
  logic                underrun_q, underrun_d;

  logic   active;
  logic   boundary;
  logic   load;
  alpha_t alpha_new;

  soqpsk_precoder u_precoder (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (~tx_en),
    .load    (load),
    .bit_in  (bit_in),
    .alpha   (alpha_new)
  );

  // Strobe decode; a bit is only taken on the last sample of a symbol
  always_comb begin
    active   = tx_en & sample_en;
    boundary = active & (idx_q == IDX_LAST);
    load     = boundary & bit_valid;
  end

  // Address generation and symbol update; both use pre-update alpha/idx
  always_comb begin
    idx_d         = idx_q;
    alpha_cur_d   = alpha_cur_q;
    alpha_prev_d  = alpha_prev_q;
    rom_address_d = rom_address_q;
    underrun_d    = underrun_q;
    if (!tx_en) begin
      // Flush symbol state; the last address is held for the ROM
      idx_d        = '0;
      alpha_cur_d  = ALPHA_ZERO;
      alpha_prev_d = ALPHA_ZERO;
      underrun_d   = 1'b0;
    end else if (active) begin
      rom_address_d = {alpha_cur_q, alpha_prev_q, idx_q};
      idx_d         = idx_q + 1'b1;
      if (boundary) begin
        alpha_prev_d = alpha_cur_q;
        alpha_cur_d  = bit_valid ? alpha_new : ALPHA_ZERO;
        if (!bit_valid) begin
          underrun_d = 1'b1;
        end
      end
    end
  end

  // Valid pipe covers the address register plus the ROM latency; it keeps
  // draining when tx_en drops so in-flight samples are not lost
  always_comb begin
    vpipe_d = {vpipe_q[ROM_LAT-1:0], active};
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q         <= '0;
      alpha_cur_q   <= ALPHA_ZERO;
      alpha_prev_q  <= ALPHA_ZERO;
      rom_address_q <= '0;
      vpipe_q       <= '0;
      underrun_q    <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      alpha_cur_q   <= alpha_cur_d;
      alpha_prev_q  <= alpha_prev_d;
      rom_address_q <= rom_address_d;
      vpipe_q       <= vpipe_d;
      underrun_q    <= underrun_d;
    end
  end

  assign bit_ready    = load;
  assign rom_address  = rom_address_q;
  assign sample_out   = rom_q;
  assign sample_valid = vpipe_q[ROM_LAT];
  assign underrun     = underrun_q;

endmodule : soqpsk_lut_reader
`default_nettype wire
